// File: rtl/mpf_vtp_port_client_if.sv
// -----------------------------------------------------------------------------
// mpf_vtp_pkg / mpf_vtp_port_if
//
// Purpose: shared lookup payload types and the VTP translation port interface.
//   The requester (to_slave) side drives reqEn/req/flags and almostFullFromFIU.
//   It consumes almostFullToAFU, rspValid and rsp. The translation service
//   (to_client) side sees the same signals with the directions reversed.
//
// Signals:
//   reqEn             lookup request strobe (requester -> service)
//   req               lookup payload
//   reqAddrIsVirtual  address needs translation
//   reqIsOrdered      ordered request (fence)
//   almostFullToAFU   service can accept only a few more requests
//   rspValid          lookup response strobe (service -> requester)
//   rsp               response payload
//   almostFullFromFIU requester response buffer is nearly full
// -----------------------------------------------------------------------------
package mpf_vtp_pkg;

    typedef struct packed {
        logic [7:0]  tag;
        logic [47:0] va;
    } t_mpf_vtp_lookup_req;

    typedef struct packed {
        logic [7:0]  tag;
        logic [47:0] pa;
        logic        error;
    } t_mpf_vtp_lookup_rsp;

endpackage

interface mpf_vtp_port_if;
    import mpf_vtp_pkg::*;

    logic                reqEn;
    t_mpf_vtp_lookup_req req;
    logic                reqAddrIsVirtual;
    logic                reqIsOrdered;
    logic                almostFullToAFU;
    logic                rspValid;
    t_mpf_vtp_lookup_rsp rsp;
    logic                almostFullFromFIU;

    modport to_slave (
        output reqEn, req, reqAddrIsVirtual, reqIsOrdered, almostFullFromFIU,
        input  almostFullToAFU, rspValid, rsp
    );

    modport to_client (
        input  reqEn, req, reqAddrIsVirtual, reqIsOrdered, almostFullFromFIU,
        output almostFullToAFU, rspValid, rsp
    );

endinterface

// File: rtl/mpf_vtp_port_client.sv
// -----------------------------------------------------------------------------
// mpf_vtp_port_client
//
// Purpose: client-side driver for one VTP translation port. It buffers AFU
//   lookup requests and issues them under almost-full flow control. It tracks
//   lookups in flight, buffers responses (back-pressuring the port through
//   almostFullFromFIU) and offers a flush/drain handshake to the AFU.
//
// Optional feature macro: MPF_VTP_PORT_CLIENT_STATS_EN
//   When defined, it adds 32-bit wrapping counters stat_req_issued,
//   stat_rsp_recv and stat_af_stall_cycles.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   afu_req_valid/ready    AFU request handshake (ready = room and RUN state)
//   afu_req                lookup payload
//   afu_req_is_virtual     address needs translation
//   afu_req_is_ordered     ordered request; combined with is_virtual it is illegal
//   afu_rsp_valid/ready    AFU response handshake
//   afu_rsp                response payload (head of response FIFO)
//   vtp                    VTP port, requester side
//   flush_req              pulse to start a drain
//   flush_done             one-cycle pulse when the drain finishes
//   outstanding            lookups in flight
//   err_illegal            sticky: virtual+ordered request was dropped
//   err_rsp_overflow       sticky: response dropped on a full FIFO
// -----------------------------------------------------------------------------
module mpf_vtp_port_client
    import mpf_vtp_pkg::*;
#(
    parameter int REQ_DEPTH       = 8,
    parameter int RSP_DEPTH       = 16,
    parameter int MAX_OUTSTANDING = 16,
    parameter int RSP_AF_THRESH   = 4
)(
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    afu_req_valid,
    output logic                                    afu_req_ready,
    input  t_mpf_vtp_lookup_req                     afu_req,
    input  logic                                    afu_req_is_virtual,
    input  logic                                    afu_req_is_ordered,
    output logic                                    afu_rsp_valid,
    input  logic                                    afu_rsp_ready,
    output t_mpf_vtp_lookup_rsp                     afu_rsp,
    mpf_vtp_port_if.to_slave                        vtp,
    input  logic                                    flush_req,
    output logic                                    flush_done,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]    outstanding,
    output logic                                    err_illegal,
    output logic                                    err_rsp_overflow
`ifdef MPF_VTP_PORT_CLIENT_STATS_EN
    ,
    output logic [31:0]                             stat_req_issued,
    output logic [31:0]                             stat_rsp_recv,
    output logic [31:0]                             stat_af_stall_cycles
`endif
);

    localparam int QAW = $clog2(REQ_DEPTH);
    localparam int RAW = $clog2(RSP_DEPTH);
    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [QAW:0]  REQ_FULL_C   = (QAW+1)'(REQ_DEPTH);
    localparam logic [RAW:0]  RSP_FULL_C   = (RAW+1)'(RSP_DEPTH);
    localparam logic [RAW:0]  RSP_THRESH_C = (RAW+1)'(RSP_AF_THRESH);
    localparam logic [OW-1:0] MAX_OUT_C    = OW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } t_state;

    typedef struct packed {
        t_mpf_vtp_lookup_req req;
        logic                is_virtual;
        logic                is_ordered;
    } t_req_entry;

    // Request FIFO: pointers carry one extra bit so full and empty differ.
    t_req_entry        req_mem_q [REQ_DEPTH];
    logic [QAW:0]      req_wr_q, req_wr_d, req_rd_q, req_rd_d;
    logic [QAW:0]      req_count_d;
    logic              req_empty_s;

    // Response FIFO
    t_mpf_vtp_lookup_rsp rsp_mem_q [RSP_DEPTH];
    logic [RAW:0]      rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d;
    logic [RAW:0]      rsp_count_s;
    logic              rsp_full_s;
    logic              rsp_push_s, rsp_pop_s;

    t_state            state_q, state_d;
    logic [OW-1:0]     outstanding_q, outstanding_d;

    logic              accept_s, illegal_s, legal_s;
    logic              issue_ok_s, pop_s, bypass_s, enq_s, issue_s;
    t_req_entry        incoming_s, issue_entry_s;

    // Registered outputs
    logic              req_en_q, req_en_d;
    t_req_entry        req_out_q, req_out_d;
    logic              ready_q, ready_d;
    logic              flush_done_q, flush_done_d;
    logic              err_illegal_q, err_illegal_d;
    logic              err_ovf_q, err_ovf_d;

    assign incoming_s  = '{req: afu_req, is_virtual: afu_req_is_virtual,
                           is_ordered: afu_req_is_ordered};
    assign req_empty_s = (req_wr_q == req_rd_q);
    assign rsp_count_s = rsp_wr_q - rsp_rd_q;
    assign rsp_full_s  = (rsp_count_s == RSP_FULL_C);

    assign accept_s  = afu_req_valid && ready_q;
    assign illegal_s = accept_s && afu_req_is_virtual && afu_req_is_ordered;
    assign legal_s   = accept_s && !illegal_s;

    // almostFullToAFU is honoured in the same cycle; DRAIN keeps issuing.
    assign issue_ok_s = !vtp.almostFullToAFU && (outstanding_q < MAX_OUT_C) &&
                        ((state_q == ST_RUN) || (state_q == ST_DRAIN));
    assign pop_s      = !req_empty_s && issue_ok_s;
    // An empty FIFO lets a new request go straight to the issue registers,
    // giving reqEn in the cycle right after acceptance.
    assign bypass_s   = legal_s && req_empty_s && issue_ok_s;
    assign enq_s      = legal_s && !bypass_s;
    assign issue_s    = pop_s || bypass_s;

    assign rsp_push_s = vtp.rspValid && !rsp_full_s;
    assign rsp_pop_s  = afu_rsp_valid && afu_rsp_ready;

    // Issue source select, FIFO pointer and count updates
    always_comb begin
        issue_entry_s = req_mem_q[req_rd_q[QAW-1:0]];
        if (bypass_s) begin
            issue_entry_s = incoming_s;
        end else begin
            issue_entry_s = req_mem_q[req_rd_q[QAW-1:0]];
        end
        req_wr_d    = req_wr_q + {{QAW{1'b0}}, enq_s};
        req_rd_d    = req_rd_q + {{QAW{1'b0}}, pop_s};
        req_count_d = req_wr_d - req_rd_d;
        rsp_wr_d    = rsp_wr_q + {{RAW{1'b0}}, rsp_push_s};
        rsp_rd_d    = rsp_rd_q + {{RAW{1'b0}}, rsp_pop_s};
    end

    // In-flight counter: +1 on issue, -1 on response, saturating at zero
    always_comb begin
        outstanding_d = outstanding_q;
        if (issue_s && !vtp.rspValid) begin
            outstanding_d = outstanding_q + OW'(1'b1);
        end else if (!issue_s && vtp.rspValid) begin
            if (outstanding_q != '0) begin
                outstanding_d = outstanding_q - OW'(1'b1);
            end else begin
                outstanding_d = outstanding_q;
            end
        end else begin
            outstanding_d = outstanding_q;
        end
    end

    // Flush FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (flush_req) state_d = ST_DRAIN;
                else           state_d = ST_RUN;
            end
            ST_DRAIN: begin
                if (req_empty_s && (outstanding_q == '0)) state_d = ST_DONE;
                else                                      state_d = ST_DRAIN;
            end
            ST_DONE: state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        req_en_d      = issue_s;
        req_out_d     = req_out_q;
        if (issue_s) begin
            req_out_d = issue_entry_s;
        end else begin
            req_out_d = req_out_q;
        end
        // Ready looks one cycle ahead so it is valid for the next cycle's count
        ready_d       = (state_d == ST_RUN) && (req_count_d != REQ_FULL_C);
        flush_done_d  = (state_q == ST_DRAIN) && (state_d == ST_DONE);
        err_illegal_d = err_illegal_q || illegal_s;
        err_ovf_d     = err_ovf_q || (vtp.rspValid && rsp_full_s);
    end

    // Control state and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_wr_q      <= '0;
            req_rd_q      <= '0;
            rsp_wr_q      <= '0;
            rsp_rd_q      <= '0;
            state_q       <= ST_RUN;
            outstanding_q <= '0;
            req_en_q      <= 1'b0;
            req_out_q     <= '0;
            ready_q       <= 1'b0;
            flush_done_q  <= 1'b0;
            err_illegal_q <= 1'b0;
            err_ovf_q     <= 1'b0;
        end else begin
            req_wr_q      <= req_wr_d;
            req_rd_q      <= req_rd_d;
            rsp_wr_q      <= rsp_wr_d;
            rsp_rd_q      <= rsp_rd_d;
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            req_en_q      <= req_en_d;
            req_out_q     <= req_out_d;
            ready_q       <= ready_d;
            flush_done_q  <= flush_done_d;
            err_illegal_q <= err_illegal_d;
            err_ovf_q     <= err_ovf_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers qualify them
    always_ff @(posedge clk) begin
        if (enq_s) begin
            req_mem_q[req_wr_q[QAW-1:0]] <= incoming_s;
        end
        if (rsp_push_s) begin
            rsp_mem_q[rsp_wr_q[RAW-1:0]] <= vtp.rsp;
        end
    end

    assign vtp.reqEn             = req_en_q;
    assign vtp.req               = req_out_q.req;
    assign vtp.reqAddrIsVirtual  = req_out_q.is_virtual;
    assign vtp.reqIsOrdered      = req_out_q.is_ordered;
    assign vtp.almostFullFromFIU = ((RSP_FULL_C - rsp_count_s) <= RSP_THRESH_C);

    assign afu_req_ready    = ready_q;
    assign afu_rsp_valid    = (rsp_count_s != '0);
    // Payload is masked to zero when empty so it is clean out of reset
    assign afu_rsp          = afu_rsp_valid ? rsp_mem_q[rsp_rd_q[RAW-1:0]] : '0;
    assign flush_done       = flush_done_q;
    assign outstanding      = outstanding_q;
    assign err_illegal      = err_illegal_q;
    assign err_rsp_overflow = err_ovf_q;

`ifdef MPF_VTP_PORT_CLIENT_STATS_EN
    logic [31:0] stat_req_q, stat_rsp_q, stat_stall_q;

    // Event counters, wrapping at 2^32
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_req_q   <= 32'd0;
            stat_rsp_q   <= 32'd0;
            stat_stall_q <= 32'd0;
        end else begin
            if (issue_s) stat_req_q <= stat_req_q + 32'd1;
            else         stat_req_q <= stat_req_q;
            if (vtp.rspValid) stat_rsp_q <= stat_rsp_q + 32'd1;
            else              stat_rsp_q <= stat_rsp_q;
            if (!req_empty_s && vtp.almostFullToAFU) stat_stall_q <= stat_stall_q + 32'd1;
            else                                     stat_stall_q <= stat_stall_q;
        end
    end

    assign stat_req_issued      = stat_req_q;
    assign stat_rsp_recv        = stat_rsp_q;
    assign stat_af_stall_cycles = stat_stall_q;
`endif

endmodule
